// File: rtl/kelvin_pkg.sv
// Shared fetch-stage types and constants: word width, the NOP encoding,
// fetch FSM states and the prefetch FIFO entry layout.
package kelvin_pkg;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] instr;
    logic [WORD_WIDTH-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
    return addr & ~WORD_WIDTH'(3);
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous prefetch FIFO of {instr, pc} entries with flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module if_prefetch_fifo
  import kelvin_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t      mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy; flush empties the FIFO without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: issues instruction-memory requests, buffers returned
// words in a prefetch FIFO and presents the oldest one to decode with its PC.
module if_prefetch_unit
  import kelvin_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en_i,
  input  logic [WORD_WIDTH-1:0] pc_start_addr_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  input  logic                  stall_i,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [WORD_WIDTH-1:0] pc_o,
  output logic [WORD_WIDTH-1:0] pc_plus4_o,
  output logic                  no_op_flag_o
);

  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 2);

  fetch_state_t          state_r;
  fetch_state_t          state_next_s;
  logic                  req_r;
  logic [WORD_WIDTH-1:0] fetch_pc_r;
  logic                  redir_pend_r;
  logic [WORD_WIDTH-1:0] redir_pc_r;
  logic [WORD_WIDTH-1:0] resp_pc_r;
  logic [CNT_W-1:0]      outst_cnt_r;
  logic [CNT_W-1:0]      drop_cnt_r;
  logic [CNT_W-1:0]      outst_next_s;
  logic [CNT_W-1:0]      drop_next_s;
  logic [FC_W-1:0]       fifo_count_s;
  logic [FC_W-1:0]       fifo_count_next_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  fetch_entry_t          head_s;
  fetch_entry_t          push_entry_s;
  logic                  gnt_s;
  logic                  pending_s;
  logic                  rv_s;
  logic                  drop_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  can_issue_s;
  logic                  boot_s;
  logic [WORD_WIDTH-1:0] target_s;

  assign target_s  = word_align(branch_target_i);
  assign gnt_s     = (state_r == REQ) && instr_gnt_i;
  assign pending_s = (state_r == REQ) && !instr_gnt_i;
  // A response with nothing in flight is stray (e.g. after reset) and is ignored.
  assign rv_s      = instr_rvalid_i && (outst_cnt_r != CNT_W'(0));
  assign drop_s    = rv_s && (drop_cnt_r != CNT_W'(0));
  assign push_s    = rv_s && !drop_s && !branch_i && (!fifo_full_s || pop_s);
  assign pop_s     = !fifo_empty_s && !stall_i && !branch_i;
  assign boot_s    = (state_r == IDLE) && (state_next_s == REQ);

  assign push_entry_s = '{instr: instr_rdata_i, pc: resp_pc_r};

  // Next-cycle occupancy including this cycle's grant, response, pop and flush.
  always_comb begin
    outst_next_s      = outst_cnt_r + CNT_W'(gnt_s) - CNT_W'(rv_s);
    fifo_count_next_s = fifo_count_s;
    drop_next_s       = drop_cnt_r - CNT_W'(drop_s);
    if (branch_i) begin
      fifo_count_next_s = '0;
      drop_next_s       = outst_next_s + CNT_W'(pending_s);
    end else if (push_s && !pop_s) begin
      fifo_count_next_s = fifo_count_s + FC_W'(1);
    end else if (!push_s && pop_s) begin
      fifo_count_next_s = fifo_count_s - FC_W'(1);
    end else begin
      fifo_count_next_s = fifo_count_s;
    end
  end

  assign can_issue_s = ((32'(fifo_count_next_s) + 32'(outst_next_s)) < 32'(FIFO_DEPTH)) &&
                       (outst_next_s < CNT_W'(MAX_OUTST));

  // Fetch FSM next state; a presented request is only left once granted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (fetch_en_i && can_issue_s) state_next_s = REQ;
        else                           state_next_s = IDLE;
      end
      REQ: begin
        if (!instr_gnt_i)      state_next_s = REQ;
        else if (!fetch_en_i)  state_next_s = IDLE;
        else if (can_issue_s)  state_next_s = REQ;
        else                   state_next_s = WAIT;
      end
      WAIT: begin
        if (!fetch_en_i)       state_next_s = IDLE;
        else if (can_issue_s)  state_next_s = REQ;
        else                   state_next_s = WAIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state and registered request strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      req_r   <= (state_next_s == REQ);
    end
  end

  // In-flight and to-be-discarded response counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst_cnt_r <= '0;
      drop_cnt_r  <= '0;
    end else begin
      outst_cnt_r <= outst_next_s;
      drop_cnt_r  <= drop_next_s;
    end
  end

  // Fetch PC; a redirect arriving under an ungranted request is parked until that grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r   <= '0;
      redir_pend_r <= 1'b0;
      redir_pc_r   <= '0;
    end else if (branch_i && pending_s) begin
      redir_pend_r <= 1'b1;
      redir_pc_r   <= target_s;
    end else if (branch_i) begin
      fetch_pc_r   <= target_s;
      redir_pend_r <= 1'b0;
    end else if (gnt_s) begin
      fetch_pc_r   <= redir_pend_r ? redir_pc_r : fetch_pc_r + WORD_WIDTH'(4);
      redir_pend_r <= 1'b0;
    end else if (boot_s) begin
      fetch_pc_r   <= word_align(pc_start_addr_i);
    end
  end

  // PC tagged onto each accepted response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_pc_r <= '0;
    end else if (branch_i) begin
      resp_pc_r <= target_s;
    end else if (push_s) begin
      resp_pc_r <= resp_pc_r + WORD_WIDTH'(4);
    end else if (boot_s) begin
      resp_pc_r <= word_align(pc_start_addr_i);
    end
  end

  if_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (branch_i),
    .wdata (push_entry_s),
    .rdata (head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign instr_req_o  = req_r;
  assign instr_addr_o = fetch_pc_r;
  assign no_op_flag_o = fifo_empty_s;
  assign instr_o      = fifo_empty_s ? NOP_INSTR : head_s.instr;
  assign pc_o         = fifo_empty_s ? WORD_WIDTH'(0) : head_s.pc;
  assign pc_plus4_o   = pc_o + WORD_WIDTH'(4);

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized scoreboard bench for if_prefetch_unit: a memory model answers granted
// requests; an epoch-tagged reference model predicts the ordered {instr, pc} stream.
module tb_if_prefetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] pc_start;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        branch;
  logic [31:0] target;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        no_op;

  always #5 clk = ~clk;

  if_prefetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en_i      (fetch_en),
    .pc_start_addr_i (pc_start),
    .instr_req_o     (req),
    .instr_addr_o    (addr),
    .instr_gnt_i     (gnt),
    .instr_rvalid_i  (rvalid),
    .instr_rdata_i   (rdata),
    .branch_i        (branch),
    .branch_target_i (target),
    .stall_i         (stall),
    .instr_o         (instr),
    .pc_o            (pc),
    .pc_plus4_o      (pc_plus4),
    .no_op_flag_o    (no_op)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    int          epoch;
    logic [31:0] addr;
    int          ready;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int gnt_pct, rv_pct, stall_pct, br_pct;
  int epoch, pres_epoch, cyc;
  bit mon_en = 1'b0;
  bit pres_open, prev_req, p_gnt, p_rvalid, p_branch;
  logic [31:0] prev_addr, p_target, model_issue_pc, model_resp_pc;
  mreq_t p_tag;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: compares the presented head against the scoreboard and retires it on a pop.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("bubble_flag", {31'd0, no_op}, 32'd1);
        check("bubble_instr", instr, NOP);
      end else begin
        check("head_flag", {31'd0, no_op}, 32'd0);
        check("head_instr", instr, exp_q[0].instr);
        check("head_pc", pc, exp_q[0].pc);
        check("head_pc4", pc_plus4, exp_q[0].pc + 32'd4);
        if (!stall && !branch) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic drive_idle();
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; branch = 1'b0; target = '0; stall = 1'b0;
  endtask

  task automatic reset_model(input logic [31:0] start);
    exp_q.delete();
    mem_q.delete();
    epoch = 0; pres_open = 1'b0; prev_req = 1'b0;
    p_gnt = 1'b0; p_rvalid = 1'b0; p_branch = 1'b0;
    model_issue_pc = start; model_resp_pc = start; cyc = 0;
  endtask

  // One cycle: fold last cycle's inputs into the model, check requests, pick new inputs.
  task automatic step();
    mreq_t t;
    if (p_rvalid && !p_branch && p_tag.epoch == epoch) begin
      exp_q.push_back('{mem_word(model_resp_pc), model_resp_pc});
      model_resp_pc += 32'd4;
    end
    if (p_branch) begin
      exp_q.delete();
      epoch++;
      model_resp_pc  = p_target;
      model_issue_pc = p_target;
    end
    if (prev_req && !p_gnt) begin
      check("req_hold", {31'd0, req}, 32'd1);
      check("addr_hold", addr, prev_addr);
    end
    if (req && !pres_open) begin
      pres_open  = 1'b1;
      pres_epoch = epoch;
    end
    gnt = req && ($urandom_range(99) < gnt_pct);
    if (gnt) begin
      if (pres_epoch == epoch) begin
        check("req_addr", addr, model_issue_pc);
        model_issue_pc += 32'd4;
      end
      mem_q.push_back('{pres_epoch, addr, cyc + 1});
      check("max_outst", (mem_q.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
      pres_open = 1'b0;
    end
    rvalid = 1'b0;
    rdata  = '0;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(99) < rv_pct) begin
      t      = mem_q.pop_front();
      rvalid = 1'b1;
      rdata  = mem_word(t.addr);
      p_tag  = t;
    end
    stall    = ($urandom_range(99) < stall_pct);
    branch   = ($urandom_range(99) < br_pct);
    target   = 32'h0000_0200 + 32'($urandom_range(0, 1023));
    p_target = target & 32'hFFFF_FFFC;
    p_gnt = gnt; p_rvalid = rvalid; p_branch = branch;
    prev_req = req; prev_addr = addr;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_boot();
    gnt_pct = 100; rv_pct = 100; stall_pct = 0; br_pct = 0;
    for (int i = 0; i < 20; i++) begin
      check("boot_flag", {31'd0, no_op}, (cyc < 3) ? 32'd1 : 32'd0);
      step();
    end
  endtask

  task automatic run_random(input int n, input int g, input int r, input int s, input int b);
    gnt_pct = g; rv_pct = r; stall_pct = s; br_pct = b;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; pc_start = 32'h0000_0080;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, 32'd0);
    check("rst_pc4", pc_plus4, 32'd4);
    check("rst_flag", {31'd0, no_op}, 32'd1);

    rst = 1'b0;
    reset_model(32'h0000_0080);
    mon_en   = 1'b1;
    fetch_en = 1'b1;
    run_boot();

    gnt_pct = 100; rv_pct = 100; stall_pct = 100; br_pct = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("stall_wait_req", {31'd0, req}, 32'd0);
      step();
    end
    run_random(10, 100, 100, 0, 0);
    run_random(3000, 60, 60, 25, 4);
    run_random(1500, 25, 70, 15, 8);

    run_random(20, 0, 100, 0, 0);
    check("drain", 32'(mem_q.size()), 32'd0);
    gnt_pct = 100; rv_pct = 0;
    for (int i = 0; i < 50 && mem_q.size() != 1; i++) step();
    check("one_outst", 32'(mem_q.size()), 32'd1);

    mon_en = 1'b0;
    rst = 1'b1;
    drive_idle();
    #2;
    check("mid_rst_req", {31'd0, req}, 32'd0);
    check("mid_rst_addr", addr, 32'd0);
    check("mid_rst_instr", instr, NOP);
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_pc4", pc_plus4, 32'd4);
    check("mid_rst_flag", {31'd0, no_op}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; fetch_en = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rvalid = 1'b0; rdata = '0;
    check("stray_flag", {31'd0, no_op}, 32'd1);
    check("stray_req", {31'd0, req}, 32'd0);
    @(posedge clk);
    #1;

    pc_start = 32'h0000_0100;
    reset_model(32'h0000_0100);
    fetch_en = 1'b1;
    mon_en   = 1'b1;
    run_boot();
    run_random(1000, 60, 60, 25, 4);
    check("progress", (pops > 500) ? 32'd1 : 32'd0, 32'd1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
